pixel_block_serializer: RTL

//  Reader-side counterpart of the 64x8-bit block buffer. It takes one packed
//  8x8 pixel block (512 bits, element 0 in the MSBs) through a valid/ready load

---
 rtl/pixel_block_serializer_if.sv | 25 ++
 rtl/pixel_block_serializer.sv | 106 ++++++++++
 2 files changed

// File: rtl/pixel_block_serializer_if.sv
// Load/stream bus of the pixel block serializer: one 8x8 block in, one element per beat out.
interface pixel_block_serializer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH*64-1:0]  in_block;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     out_data;
    logic [5:0]                out_index;
    logic                      out_last;

    // Serializer side
    modport slave (
        input  in_valid, in_block, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last
    );

    // Block producer / stream consumer side
    modport master (
        output in_valid, in_block, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/pixel_block_serializer.sv
// Holds one 8x8 pixel block and streams its elements one per beat,
// in raster or JPEG zigzag order, with no bubble between consecutive blocks.
module pixel_block_serializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ZIGZAG     = 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    pixel_block_serializer_if.slave   bus,
    output logic                      busy
);
    localparam int unsigned CNT_W = 6;
    localparam int unsigned LAST  = DEPTH - 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    localparam int ZZ_TABLE [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    logic [0:0]            state;
    logic [0:0]            state_next;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic                  load;
    logic                  at_last;
    logic [CNT_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] bank [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state, handshakes and stream outputs
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        at_last       = (cnt == CNT_W'(LAST));
        rd_idx        = (ZIGZAG != 0) ? CNT_W'(ZZ_TABLE[cnt]) : cnt;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_index = '0;
        bus.out_data  = '0;
        load          = 1'b0;

        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                load         = bus.in_valid;
                if (load) begin
                    state_next = SEND;
                    cnt_next   = '0;
                end
            end
            SEND: begin
                bus.out_valid = 1'b1;
                bus.out_last  = at_last;
                bus.out_index = cnt;
                bus.out_data  = bank[rd_idx];
                bus.in_ready  = at_last & bus.out_ready;
                load          = bus.in_valid & bus.in_ready;
                if (bus.out_ready) begin
                    if (!at_last) begin
                        cnt_next = cnt + CNT_W'(1);
                    end else begin
                        cnt_next = '0;
                        if (!load) begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        busy = bus.out_valid;
    end

    // Element bank, element 0 taken from the MSBs of the packed block
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                bank[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                bank[i] <= bus.in_block[(63 - i) * int'(DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end
endmodule
